// File: rtl/count_event_monitor_if.sv
// Counter-sample inputs and timestamped-event drain port of count_event_monitor.
// The monitor uses the master view; the producer/consumer side uses slave.
interface count_event_monitor_if #(
  parameter int CNT_W = 4,
  parameter int TS_W  = 8,
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count_in;
  logic             match_en;
  logic [CNT_W-1:0] match_val;
  logic             evt_ready;
  logic             evt_valid;
  logic [2:0]       evt_flags;
  logic [CNT_W-1:0] evt_count;
  logic [TS_W-1:0]  evt_stamp;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;

  modport master (
    input  count_in, match_en, match_val, evt_ready,
    output evt_valid, evt_flags, evt_count, evt_stamp, fifo_level, overflow
  );

  modport slave (
    output count_in, match_en, match_val, evt_ready,
    input  evt_valid, evt_flags, evt_count, evt_stamp, fifo_level, overflow
  );
endinterface

// File: rtl/count_event_monitor.sv
// Watches a small up-counter for match / wrap / clear events and queues
// timestamped records in a first-word-fall-through FIFO drained via valid/ready.

module count_event_detect #(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] cur_i,
  input  logic [CNT_W-1:0] prev_i,
  input  logic             prev_valid_i,
  input  logic             match_en_i,
  input  logic [CNT_W-1:0] match_val_i,
  output logic [2:0]       flags_o
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic changed;
  assign changed = prev_valid_i && (cur_i != prev_i);

  // flags = {clear, wrap, match}; a held value never re-triggers
  always_comb begin
    flags_o = '0;
    if (changed) begin
      flags_o[2] = (cur_i == '0) && (prev_i != MAX);
      flags_o[1] = (cur_i == '0) && (prev_i == MAX);
      flags_o[0] = match_en_i && (cur_i == match_val_i);
    end
  end
endmodule

module count_event_monitor #(
  parameter int CNT_W = 4,
  parameter int TS_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  count_event_monitor_if.master evt_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef struct packed {
    logic [2:0]       flags;
    logic [CNT_W-1:0] count;
    logic [TS_W-1:0]  stamp;
  } entry_t;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  entry_t           mem_q [DEPTH];

  logic [2:0] flags;
  logic       push_req, push_ok, pop, valid;
  entry_t     new_entry, head;

  count_event_detect #(.CNT_W(CNT_W)) u_detect (
    .cur_i        (evt_if.count_in),
    .prev_i       (prev_q),
    .prev_valid_i (prev_valid_q),
    .match_en_i   (evt_if.match_en),
    .match_val_i  (evt_if.match_val),
    .flags_o      (flags)
  );

  assign valid     = (level_q != '0);
  assign pop       = valid && evt_if.evt_ready;
  assign push_req  = |flags;
  // a pop in the same cycle frees the slot the push lands in
  assign push_ok   = push_req && ((level_q != FULL_LVL) || pop);
  assign new_entry = '{flags: flags, count: evt_if.count_in, stamp: ts_q};

  always_comb begin
    ts_d         = ts_q + TS_W'(1);
    prev_d       = evt_if.count_in;
    prev_valid_d = 1'b1;
    rd_ptr_d     = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d     = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    overflow_d   = overflow_q || (push_req && !push_ok);
    level_d      = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q         <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      ts_q         <= ts_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage is not reset: level==0 already hides stale contents.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head = mem_q[rd_ptr_q];

  assign evt_if.evt_valid  = valid;
  assign evt_if.evt_flags  = valid ? head.flags : '0;
  assign evt_if.evt_count  = valid ? head.count : '0;
  assign evt_if.evt_stamp  = valid ? head.stamp : '0;
  assign evt_if.fifo_level = level_q;
  assign evt_if.overflow   = overflow_q;
endmodule

// File: tb/tb_count_event_monitor.sv
// Randomized and directed bench for count_event_monitor against a queue model.
module tb_count_event_monitor;
  localparam int CNT_W = 4;
  localparam int TS_W  = 8;
  localparam int DEPTH = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  count_event_monitor_if #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) evt_if ();

  count_event_monitor #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .evt_if (evt_if.master)
  );

  typedef struct {
    int flags;
    int count;
    int stamp;
  } ent_t;

  ent_t q[$];
  int   ts_m, prev_m;
  bit   prev_v_m, ovf_m, armed;
  int   n_chk, n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("valid", {31'd0, evt_if.evt_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("flags", {29'd0, evt_if.evt_flags}, q[0].flags);
      chk("count", {28'd0, evt_if.evt_count}, q[0].count);
      chk("stamp", {24'd0, evt_if.evt_stamp}, q[0].stamp);
    end else begin
      chk("flags_idle", {29'd0, evt_if.evt_flags}, 0);
      chk("count_idle", {28'd0, evt_if.evt_count}, 0);
      chk("stamp_idle", {24'd0, evt_if.evt_stamp}, 0);
    end
    chk("level", {29'd0, evt_if.fifo_level}, q.size());
    chk("overflow", {31'd0, evt_if.overflow}, {31'd0, ovf_m});
  endtask

  // Reference: what the rules say happens at one rising edge.
  task automatic model_edge(input int cnt, input bit men, input int mval, input bit rdy, input bit rst);
    int flags;
    if (rst) begin
      q.delete();
      ts_m = 0; prev_v_m = 0; ovf_m = 0; prev_m = 0; armed = 1;
      return;
    end
    flags = 0;
    if (prev_v_m && cnt != prev_m) begin
      if (cnt == 0) flags |= (prev_m == MAXV) ? 2 : 4;
      if (men && cnt == mval) flags |= 1;
    end
    if (rdy && q.size() > 0) q.delete(0);
    if (flags != 0) begin
      if (q.size() < DEPTH) q.push_back('{flags: flags, count: cnt, stamp: ts_m});
      else ovf_m = 1;
    end
    prev_m = cnt; prev_v_m = 1;
    ts_m = (ts_m + 1) % (1 << TS_W);
  endtask

  task automatic step(input int cnt, input bit men, input int mval, input bit rdy, input bit rst);
    @(negedge clock);
    if (armed) check_outputs();
    reset            = rst;
    evt_if.count_in  = cnt[CNT_W-1:0];
    evt_if.match_en  = men;
    evt_if.match_val = mval[CNT_W-1:0];
    evt_if.evt_ready = rdy;
    @(posedge clock);
    model_edge(cnt, men, mval, rdy, rst);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
  endtask

  initial begin
    int c;
    n_chk = 0; n_fail = 0; armed = 0;
    evt_if.count_in = '0; evt_if.match_en = 1'b0;
    evt_if.match_val = '0; evt_if.evt_ready = 1'b0;
    do_reset();

    // first sample + single match at 5
    for (int i = 0; i <= 20; i++) step(i % 16, 1, 5, 1, 0);
    // wraps with match at 0, two laps
    for (int i = 21; i <= 60; i++) step(i % 16, 1, 0, 1, 0);
    // clear from 9
    for (int i = 0; i <= 9; i++) step(i, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // overflow: six wraps with no drain, then drain
    do_reset();
    for (int i = 0; i <= 96; i++) step(i % 16, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);

    // full FIFO, pop coinciding with a new wrap
    do_reset();
    for (int i = 0; i <= 80; i++) step(i % 16, 0, 0, i == 80, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);

    // mid-operation reset with 3 queued and overflow set
    do_reset();
    for (int i = 0; i <= 96; i++) step(i % 16, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(7, 1, 7, 0, 0);
    step(7, 1, 7, 0, 0);
    step(8, 1, 8, 1, 0);
    step(8, 1, 8, 1, 0);

    // random traffic
    c = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 6) c = (c + 1) % 16;
      else if ($urandom_range(0, 3) == 0) c = c;
      else c = $urandom_range(0, MAXV);
      step(c, $urandom_range(0, 1), $urandom_range(0, MAXV),
           $urandom_range(0, 3) != 0 ? ($urandom_range(0, 1) == 1) : 1'b0,
           $urandom_range(0, 199) == 0);
    end
    @(negedge clock);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
